universal_reg_rstn: RTL
=======================

Name: universal_reg_rstn

Overview:
- Parametrised multi-mode register with synchronous active-low reset. Successor to the single-bit level-sensitive latch.
- Edge-triggered storage of WIDTH bits. Per-cycle mode select covers hold, parallel load, shift, rotate, up-count and down-count.
- Provides true and inverted outputs, serial taps and a terminal-count flag.
- Used as the general storage/shift/count primitive in later lab blocks.

Parameters:
- WIDTH, 8, register width in bits; legal range >= 2.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into q on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset.
- enable  input  1  when 0, the register holds regardless of mode.
- mode  input  3  operation select, decoded below.
- d  input  WIDTH  parallel load data.
- sin_lsb  input  1  serial fill bit entering bit 0 on shift-left.
- sin_msb  input  1  serial fill bit entering bit WIDTH-1 on shift-right.
- q  output  WIDTH  register contents.
- q_not  output  WIDTH  bitwise ~q (combinational).
- sout_msb  output  1  q[WIDTH-1] (combinational).
- sout_lsb  output  1  q[0] (combinational).
- tc  output  1  terminal-count flag (combinational).

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low on reset_n. All state changes occur only on the rising edge of clk.
- Priority at each edge: reset_n==0, then enable==0, then mode decode.
  - reset_n==0: q <= RESET_VALUE. Overrides enable and mode. No asynchronous effect; a reset_n pulse that does not span a rising edge has no effect.
  - enable==0: q holds.
- Mode decode (enable==1, reset_n==1):
  - 3'd0 HOLD: q <= q.
  - 3'd1 LOAD: q <= d.
  - 3'd2 SHL: q <= {q[WIDTH-2:0], sin_lsb}.
  - 3'd3 SHR: q <= {sin_msb, q[WIDTH-1:1]}.
  - 3'd4 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 3'd5 ROR: q <= {q[0], q[WIDTH-1:1]}.
  - 3'd6 INC: q <= q + 1, modulo 2^WIDTH. All-ones wraps to 0.
  - 3'd7 DEC: q <= q - 1, modulo 2^WIDTH. 0 wraps to all-ones.
- Latency: one cycle from the sampling edge to the new q. q_not, sout_msb, sout_lsb and tc follow q combinationally in the same cycle.
- tc:
  - 1 when enable==1 && reset_n==1 && ((mode==INC && q=={WIDTH{1'b1}}) || (mode==DEC && q==0)).
  - Otherwise 0, including while reset_n==0.
  - Announces the wrap that occurs on the next edge.
- Outputs during and after reset: q=RESET_VALUE, q_not=~RESET_VALUE, sout_msb/sout_lsb = the corresponding RESET_VALUE bits, tc=0.
- Reset asserted mid-count or mid-shift: the sequence is abandoned. The next edge yields RESET_VALUE, with no partial update.
- Mode or d changes between edges have no effect on q. Only values sampled at the edge matter.
- Inputs are assumed free of X. A mode value of X must not corrupt tc in simulation; tc evaluates to 0.

Optional Feature:
- Macro: UNIVERSAL_REG_ROTATE_EN.
- Defined: ROL (3'd4) and ROR (3'd5) operate as specified above.
- Undefined: rotate logic is not compiled in. Mode codes 3'd4 and 3'd5 behave as HOLD (q unchanged). All other modes and tc are unaffected.

Test Plan:
- Reset priority: WIDTH=8, RESET_VALUE=8'hA5. Hold reset_n=0 with enable=1, mode=LOAD, d=8'hFF for 2 edges -> q=8'hA5, q_not=8'h5A, tc=0. Then a reset_n glitch low between edges -> q unchanged.
- Load/hold/enable: reset_n=1, mode=LOAD, d=8'h3C -> next edge q=8'h3C. Then enable=0 with d=8'h00 for 3 edges -> q stays 8'h3C.
- Shifts: q=8'h81.
  - SHL with sin_lsb=0 -> 8'h02, sout_msb=0.
  - Then SHR with sin_msb=1 -> 8'h81.
  - Then SHR with sin_msb=1 -> 8'hC0, sout_lsb=0.
- Rotates, with macro defined: q=8'h81, ROL -> 8'h03, ROR -> 8'h81, ROR -> 8'hC0.
- Rotates, macro undefined: same stimulus -> q stays 8'h81.
- Count wrap and tc:
  - LOAD 8'hFE, then INC: tc=0 at q=FE; tc=1 at q=FF; next edge q=8'h00 with tc=0.
  - Switch to DEC at q=00: tc=1; next edge q=8'hFF.
- Reset mid-count: INC from 8'h10 for 3 edges (q=8'h13), then reset_n=0 for one edge -> q=8'hA5 (RESET_VALUE); after release, INC resumes from 8'hA5 -> 8'hA6.

Source files
------------

// File: rtl/universal_reg_rstn.sv
// universal_reg_rstn: WIDTH-bit multi-mode register (hold/load/shift/rotate/count) with synchronous active-low reset
// Ports: clk, reset_n (sync, active-low), enable, mode[2:0], d[WIDTH-1:0], sin_lsb, sin_msb
//        -> q, q_not, sout_msb, sout_lsb, tc (wrap announced for the next edge)
// Optional: define UNIVERSAL_REG_ROTATE_EN to compile in ROL/ROR; otherwise modes 4/5 hold.
module universal_reg_rstn #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_not,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic             tc
);
  logic [WIDTH-1:0] nxt;
  always_comb begin
    nxt = q;
    if (enable)
      case (mode)
        3'd1: nxt = d;
        3'd2: nxt = {q[WIDTH-2:0], sin_lsb};
        3'd3: nxt = {sin_msb, q[WIDTH-1:1]};
`ifdef UNIVERSAL_REG_ROTATE_EN
        3'd4: nxt = {q[WIDTH-2:0], q[WIDTH-1]};
        3'd5: nxt = {q[0], q[WIDTH-1:1]};
`endif
        3'd6: nxt = q + 1'b1;
        3'd7: nxt = q - 1'b1;
        default: nxt = q;
      endcase
  end
  always_ff @(posedge clk) q <= !reset_n ? RESET_VALUE : nxt;
  assign q_not = ~q;
  assign sout_msb = q[WIDTH-1];
  assign sout_lsb = q[0];
  // case-equality keeps tc at 0 when mode is X in simulation
  assign tc = reset_n && enable && ((mode === 3'd6 && &q) || (mode === 3'd7 && ~|q));
endmodule
